// File: rtl/xpb_pkg.sv
// xpb_pkg: FSM encoding and default sizes shared by the xpb accumulator and digit sequencer.
package xpb_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} xpb_state_e;
  localparam int XPB_WIDTH = 1024;
  localparam int XPB_NUM_TERMS = 8;
  localparam int XPB_CHUNK = 128;
  function automatic int xpb_rw(input int width, input int num_terms);
    return width + $clog2(num_terms + 1);
  endfunction
endpackage

// File: rtl/xpb_accum_if.sv
// xpb_accum_if: start/term/result bundle between the xpb tables and the reduction accumulator.
interface xpb_accum_if
  import xpb_pkg::*;
#(
  parameter int WIDTH = XPB_WIDTH,
  parameter int NUM_TERMS = XPB_NUM_TERMS
);
  localparam int RW = xpb_rw(WIDTH, NUM_TERMS);
  logic start;
  logic [WIDTH-1:0] low_in;
  logic term_valid;
  logic [WIDTH-1:0] term_in;
  logic busy;
  logic out_valid;
  logic [RW-1:0] result;
  modport master (output start, low_in, term_valid, term_in, input busy, out_valid, result);
  modport slave (input start, low_in, term_valid, term_in, output busy, out_valid, result);
endinterface

// File: rtl/xpb_csa.sv
// xpb_csa: RW-bit 3:2 compressor giving bitwise sum and left-shifted majority carry.
module xpb_csa #(
  parameter int RW = 1028
) (
  input  logic [RW-1:0] a_i,
  input  logic [RW-1:0] b_i,
  input  logic [RW-1:0] c_i,
  output logic [RW-1:0] sum_o,
  output logic [RW-1:0] carry_o
);
  assign sum_o = a_i ^ b_i ^ c_i;
  assign carry_o = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;
endmodule

// File: rtl/xpb_accum.sv
// xpb_accum: carry-save sum of low_in and NUM_TERMS xpb words, then chunked carry resolve.
module xpb_accum
  import xpb_pkg::*;
#(
  parameter int WIDTH = XPB_WIDTH,
  parameter int NUM_TERMS = XPB_NUM_TERMS,
  parameter int CHUNK = XPB_CHUNK
) (
  input logic clk,
  input logic rst,
  xpb_accum_if.slave bus
);
  localparam int RW = xpb_rw(WIDTH, NUM_TERMS);
  localparam int K = (RW + CHUNK - 1) / CHUNK;
  localparam int PW = K * CHUNK;
  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam int KW = $clog2(K + 1);
  xpb_state_e state_q;
  logic [RW-1:0] s_q, c_q, csa_s, csa_c, result_q;
  logic [PW-1:0] s_w, c_w, r_q, r_d;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] k_q;
  logic cy_q;
  logic [CHUNK:0] part;
  xpb_csa #(.RW(RW)) u_csa (
    .a_i(s_q),
    .b_i(c_q),
    .c_i(RW'(bus.term_in)),
    .sum_o(csa_s),
    .carry_o(csa_c)
  );
  // S and C shift right one slice per RESOLVE cycle; resolved slices enter R from the top
  assign s_w = PW'(s_q);
  assign c_w = PW'(c_q);
  assign part = {1'b0, s_w[CHUNK-1:0]} + {1'b0, c_w[CHUNK-1:0]} + (CHUNK+1)'(cy_q);
  assign r_d = (r_q >> CHUNK) | (PW'(part[CHUNK-1:0]) << (PW - CHUNK));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      c_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      cy_q <= 1'b0;
      r_q <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= bus.start ? ACCUM : IDLE;
          if (bus.start) begin
            s_q <= RW'(bus.low_in);
            c_q <= '0;
            cnt_q <= '0;
          end
        end
        ACCUM: if (bus.term_valid) begin
          s_q <= csa_s;
          c_q <= csa_c;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(NUM_TERMS - 1)) begin
            state_q <= RESOLVE;
            k_q <= '0;
            cy_q <= 1'b0;
          end
        end
        RESOLVE: begin
          s_q <= RW'(s_w >> CHUNK);
          c_q <= RW'(c_w >> CHUNK);
          cy_q <= part[CHUNK];
          r_q <= r_d;
          k_q <= k_q + 1'b1;
          if (k_q == KW'(K - 1)) begin
            result_q <= r_d[RW-1:0];
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = (state_q == ACCUM) || (state_q == RESOLVE);
  assign bus.out_valid = state_q == DONE;
  assign bus.result = result_q;
endmodule
